// File: rtl/vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// vga_sync_monitor
//   Receive-side checker for an HSync/VSync timing generator. Synchronises the
//   incoming HSync pulse and VSync level, measures the line period (clocks) and
//   the frame height (lines), tracks lock to the nominal timing and exports the
//   recovered x/y position for downstream pixel logic.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   hsync_in          HSync, one-clock high pulse per line
//   vsync_in          VSync level, falling edge marks frame start
//   line_strobe       1-cycle pulse per accepted HSync rising edge
//   frame_strobe      1-cycle pulse per VSync falling edge
//   x_pos, y_pos      clocks since last line / lines since last frame
//   line_period       last measured line period (clocks)
//   frame_lines       last measured lines per frame
//   locked            timing within tolerance for LOCK_FRAMES frames
//   err_h, err_v      sticky out-of-tolerance line / frame seen while locked
//   no_signal         no HSync for 2*HPER_NOM clocks
// -----------------------------------------------------------------------------
module vga_sync_monitor #(
  parameter int HPER_NOM    = 3175,
  parameter int HPER_TOL    = 16,
  parameter int LINES_NOM   = 512,
  parameter int LINES_TOL   = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 15,
  parameter int LN_W        = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic             line_strobe,
  output logic             frame_strobe,
  output logic [CNT_W-1:0] x_pos,
  output logic [LN_W-1:0]  y_pos,
  output logic [CNT_W-1:0] line_period,
  output logic [LN_W-1:0]  frame_lines,
  output logic             locked,
  output logic             err_h,
  output logic             err_v,
  output logic             no_signal
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LN_W-1:0]  LN_ONE  = LN_W'(1);
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(2 * HPER_NOM - 1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [LN_W-1:0] sat_inc_ln(input logic [LN_W-1:0] v);
    return (&v) ? v : v + LN_ONE;
  endfunction

  function automatic logic in_tol(input int v, input int nom, input int tol);
    return (v >= nom - tol) && (v <= nom + tol);
  endfunction

  state_t           r_state;
  logic             r_hs_p0, r_hs_p1, r_hs_p2;
  logic             r_vs_p0, r_vs_p1, r_vs_p2;
  logic             r_started;    // a line strobe has been seen since SEARCH entry
  logic             r_frame_bad;  // current frame contained a bad line
  logic [3:0]       r_good_cnt;

  logic             w_line_evt, w_frame_evt;
  logic [CNT_W-1:0] w_period;
  logic [LN_W-1:0]  w_lines_end;
  logic             w_line_bad, w_lines_ok, w_frame_good, w_timeout;
  logic [3:0]       w_good_nxt;

  // p1 vs p2 comparison: edge detect on the synchronised inputs
  assign w_line_evt  = r_hs_p1 & ~r_hs_p2;
  assign w_frame_evt = ~r_vs_p1 & r_vs_p2;
  assign w_period    = sat_inc_cnt(x_pos);
  // The first strobe after SEARCH entry only starts timing
  assign w_line_bad  = w_line_evt & r_started & ~in_tol(int'(w_period), HPER_NOM, HPER_TOL);
  // A line closing in the same cycle as the frame edge belongs to the ending frame
  assign w_lines_end = w_line_evt ? sat_inc_ln(y_pos) : y_pos;
  assign w_lines_ok  = in_tol(int'(w_lines_end), LINES_NOM, LINES_TOL);
  assign w_frame_good = w_lines_ok & ~r_frame_bad & ~w_line_bad;
  assign w_timeout   = ~w_line_evt & (x_pos == TMO_M1);
  assign w_good_nxt  = r_good_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SEARCH;
      r_hs_p0      <= 1'b0;
      r_hs_p1      <= 1'b0;
      r_hs_p2      <= 1'b0;
      r_vs_p0      <= 1'b0;
      r_vs_p1      <= 1'b0;
      r_vs_p2      <= 1'b0;
      r_started    <= 1'b0;
      r_frame_bad  <= 1'b0;
      r_good_cnt   <= '0;
      line_strobe  <= 1'b0;
      frame_strobe <= 1'b0;
      x_pos        <= '0;
      y_pos        <= '0;
      line_period  <= '0;
      frame_lines  <= '0;
      locked       <= 1'b0;
      err_h        <= 1'b0;
      err_v        <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      // p0/p1: synchroniser, p2: edge-detect history
      r_hs_p0 <= hsync_in;
      r_hs_p1 <= r_hs_p0;
      r_hs_p2 <= r_hs_p1;
      r_vs_p0 <= vsync_in;
      r_vs_p1 <= r_vs_p0;
      r_vs_p2 <= r_vs_p1;

      // strobe stage: position counters and measurements
      line_strobe  <= w_line_evt;
      frame_strobe <= w_frame_evt;
      x_pos        <= w_line_evt ? '0 : sat_inc_cnt(x_pos);

      if (w_line_evt) begin
        line_period <= w_period;
        r_started   <= 1'b1;
        no_signal   <= 1'b0;
      end

      if (w_frame_evt) begin
        frame_lines <= w_lines_end;
        y_pos       <= '0;
        r_frame_bad <= 1'b0;
      end else begin
        if (w_line_evt) y_pos <= sat_inc_ln(y_pos);
        if (w_line_bad) r_frame_bad <= 1'b1;
      end

      case (r_state)
        SEARCH: begin
          if (w_frame_evt) begin
            r_state    <= ACQUIRE;
            r_good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (w_frame_evt) begin
            if (w_frame_good) begin
              r_good_cnt <= w_good_nxt;
              if (w_good_nxt >= LOCK_N) begin
                r_state <= LOCKED;
                locked  <= 1'b1;
              end
            end else begin
              r_good_cnt <= '0;
            end
          end else if (w_line_bad) begin
            r_good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (w_line_bad) err_h <= 1'b1;
          if (w_frame_evt && !w_lines_ok) err_v <= 1'b1;
          if (w_line_bad || (w_frame_evt && !w_lines_ok)) begin
            r_state    <= ACQUIRE;
            locked     <= 1'b0;
            r_good_cnt <= '0;
          end
        end
        default: r_state <= SEARCH;
      endcase

      // Loss of HSync overrides everything and restarts acquisition
      if (w_timeout) begin
        no_signal  <= 1'b1;
        r_state    <= SEARCH;
        locked     <= 1'b0;
        y_pos      <= '0;
        r_started  <= 1'b0;
        r_good_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
module tb_vga_sync_monitor;

  localparam int HPER_NOM    = 20;
  localparam int HPER_TOL    = 2;
  localparam int LINES_NOM   = 8;
  localparam int LINES_TOL   = 1;
  localparam int LOCK_FRAMES = 2;
  localparam int CNT_W       = 8;
  localparam int LN_W        = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hsync_in = 1'b0;
  logic             vsync_in = 1'b1;
  logic             line_strobe, frame_strobe;
  logic [CNT_W-1:0] x_pos, line_period;
  logic [LN_W-1:0]  y_pos, frame_lines;
  logic             locked, err_h, err_v, no_signal;

  int checks = 0;
  int failures = 0;
  int strobes;

  vga_sync_monitor #(
    .HPER_NOM(HPER_NOM), .HPER_TOL(HPER_TOL), .LINES_NOM(LINES_NOM),
    .LINES_TOL(LINES_TOL), .LOCK_FRAMES(LOCK_FRAMES), .CNT_W(CNT_W), .LN_W(LN_W)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .line_strobe(line_strobe), .frame_strobe(frame_strobe),
    .x_pos(x_pos), .y_pos(y_pos), .line_period(line_period),
    .frame_lines(frame_lines), .locked(locked), .err_h(err_h),
    .err_v(err_v), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue an HSync pulse and stop on the cycle where its line_strobe is visible
  task automatic line_head(input logic vs);
    vsync_in = vs;
    hsync_in = 1'b1;
    @(negedge clk);
    hsync_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic line_tail(input int per);
    repeat (per - 3) @(negedge clk);
  endtask

  task automatic send_line(input int per, input logic vs);
    line_head(vs);
    line_tail(per);
  endtask

  // Finish a frame whose line 0 head was already issued: n lines total
  task automatic frame_rest(input int n);
    line_tail(HPER_NOM);
    for (int i = 1; i < n; i++) send_line(HPER_NOM, (i >= n / 2));
  endtask

  initial begin
    // ---------------- reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_line_strobe", 32'(line_strobe), 0);
    check("rst_frame_strobe", 32'(frame_strobe), 0);
    check("rst_x_pos", 32'(x_pos), 0);
    check("rst_y_pos", 32'(y_pos), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_no_signal", 32'(no_signal), 0);
    repeat (5) @(negedge clk);

    // ---------------- test 1: ideal timing, lock at third frame strobe
    line_head(1'b0);
    check("t1_fs1_frame_strobe", 32'(frame_strobe), 1);
    check("t1_fs1_line_strobe", 32'(line_strobe), 1);
    check("t1_fs1_locked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("t1_fs2_line_period", 32'(line_period), 20);
    check("t1_fs2_frame_lines", 32'(frame_lines), 8);
    check("t1_fs2_locked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("t1_fs3_locked", 32'(locked), 1);
    check("t1_fs3_frame_lines", 32'(frame_lines), 8);
    check("t1_fs3_x_pos", 32'(x_pos), 0);
    check("t1_fs3_err_h", 32'(err_h), 0);
    check("t1_fs3_err_v", 32'(err_v), 0);
    frame_rest(8);

    // ---------------- test 2: one 23-clock line while locked
    line_head(1'b0);
    check("t2_still_locked", 32'(locked), 1);
    line_tail(20);
    send_line(20, 1'b0);
    send_line(20, 1'b0);
    send_line(23, 1'b0);
    line_head(1'b1);
    check("t2_line_period", 32'(line_period), 23);
    check("t2_err_h", 32'(err_h), 1);
    check("t2_unlocked", 32'(locked), 0);
    check("t2_err_v", 32'(err_v), 0);
    check("t2_y_pos", 32'(y_pos), 4);
    line_tail(20);
    for (int i = 0; i < 3; i++) send_line(20, 1'b1);
    line_head(1'b0);
    check("t2_badframe_locked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("t2_clean1_locked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("t2_relocked", 32'(locked), 1);
    check("t2_err_h_sticky", 32'(err_h), 1);

    // ---------------- test 3: short frame (6 lines) while locked
    frame_rest(6);
    line_head(1'b0);
    check("t3_frame_lines", 32'(frame_lines), 6);
    check("t3_err_v", 32'(err_v), 1);
    check("t3_unlocked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("t3_acq_locked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("t3_relocked", 32'(locked), 1);

    // ---------------- test 4: HSync stops, timeout at x_pos == 40
    line_tail(20);
    send_line(20, 1'b0);
    send_line(20, 1'b0);
    repeat (22) @(negedge clk);
    check("t4_pre_x_pos", 32'(x_pos), 39);
    check("t4_pre_no_signal", 32'(no_signal), 0);
    check("t4_pre_y_pos", 32'(y_pos), 2);
    @(negedge clk);
    check("t4_x_pos", 32'(x_pos), 40);
    check("t4_no_signal", 32'(no_signal), 1);
    check("t4_locked", 32'(locked), 0);
    check("t4_y_pos", 32'(y_pos), 0);
    repeat (10) @(negedge clk);
    line_head(1'b0);
    check("t4_resume_no_signal", 32'(no_signal), 0);
    check("t4_resume_strobe", 32'(line_strobe), 1);
    check("t4_resume_y_pos", 32'(y_pos), 1);
    line_tail(20);
    send_line(20, 1'b0);

    // ---------------- frame edge in mid-line (no coincident line strobe)
    line_head(1'b1);
    repeat (5) @(negedge clk);
    vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_frame_strobe", 32'(frame_strobe), 1);
    check("mid_line_strobe", 32'(line_strobe), 0);
    check("mid_frame_lines", 32'(frame_lines), 3);
    check("mid_y_pos", 32'(y_pos), 0);
    repeat (9) @(negedge clk);
    for (int i = 0; i < 4; i++) send_line(20, 1'b1);
    line_head(1'b0);
    check("mid_next_frame_lines", 32'(frame_lines), 5);
    check("mid_next_locked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("acq_locked", 32'(locked), 0);
    frame_rest(8);

    // ---------------- test 5: coincident line and frame edge
    line_head(1'b0);
    check("t5_frame_strobe", 32'(frame_strobe), 1);
    check("t5_line_strobe", 32'(line_strobe), 1);
    check("t5_frame_lines", 32'(frame_lines), 8);
    check("t5_locked", 32'(locked), 1);
    @(negedge clk);
    check("t5_y_pos_next", 32'(y_pos), 0);
    check("t5_x_pos_next", 32'(x_pos), 1);
    repeat (16) @(negedge clk);

    // ---------------- test 6: reset mid-frame while locked, VSync held high
    send_line(20, 1'b0);
    send_line(20, 1'b0);
    line_head(1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    vsync_in = 1'b1;
    @(negedge clk);
    check("t6_locked", 32'(locked), 0);
    check("t6_err_h", 32'(err_h), 0);
    check("t6_err_v", 32'(err_v), 0);
    check("t6_line_period", 32'(line_period), 0);
    check("t6_frame_lines", 32'(frame_lines), 0);
    check("t6_x_pos", 32'(x_pos), 0);
    check("t6_y_pos", 32'(y_pos), 0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (line_strobe || frame_strobe) strobes++;
    end
    check("t6_no_spurious_strobe", 32'(strobes), 0);
    line_head(1'b0);
    check("t6_fs1_frame_strobe", 32'(frame_strobe), 1);
    check("t6_fs1_locked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("t6_fs2_locked", 32'(locked), 0);
    frame_rest(8);
    line_head(1'b0);
    check("t6_fs3_locked", 32'(locked), 1);
    frame_rest(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
